// File: rtl/modulo_controle_contador_ocupacao.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : modulo_controle_contador_ocupacao
// Function : Occupancy controller that arbitrates entry/exit sensor requests
//            and drives direction plus a one-cycle enable to an up/down
//            counter, refusing requests at the count limits.
// Options  : DEBOUNCE_EN - adds a DEB_CYCLES-sample debounce filter per sensor
// Revision : 1.0 - initial release
// ============================================================================
module modulo_controle_contador_ocupacao #(
    parameter int WIDTH      = 7,
    parameter int MAX_COUNT  = 99,
    parameter int DEB_CYCLES = 4
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             sensor_in,
    input  logic             sensor_out,
    input  logic [WIDTH-1:0] q,
    output logic             cnt_en,
    output logic             up_down,
    output logic             full,
    output logic             empty,
    output logic             rej_in,
    output logic             rej_out,
    output logic             ovr
);

    localparam logic [WIDTH-1:0] c_MAX = MAX_COUNT[WIDTH-1:0];

    generate
        if (MAX_COUNT < 1 || MAX_COUNT > (2**WIDTH) - 1 || DEB_CYCLES < 1) begin : g_bad_param
            $error("modulo_controle_contador_ocupacao: illegal parameter set");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_SET_DIR = 2'd1,
        S_COUNT   = 2'd2,
        S_WAIT    = 2'd3
    } state_t;

    // Bit 0 carries the entry sensor, bit 1 the exit sensor.
    logic [1:0] r_sync1;
    logic [1:0] r_sync2;
    logic [1:0] r_prev;
    logic [1:0] w_lvl;
    logic [1:0] w_edge;

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_sync1 <= 2'b00;
            r_sync2 <= 2'b00;
        end else begin
            r_sync1 <= {sensor_out, sensor_in};
            r_sync2 <= r_sync1;
        end
    end

`ifdef DEBOUNCE_EN
    localparam int c_DW = $clog2(DEB_CYCLES + 1);

    logic [1:0]      r_filt;
    logic [c_DW-1:0] r_deb_cnt [2];

    // Filtered level flips on the DEB_CYCLES-th consecutive differing sample.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_filt <= 2'b00;
            for (int i = 0; i < 2; i++) begin
                r_deb_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (r_sync2[i] == r_filt[i]) begin
                    r_deb_cnt[i] <= '0;
                end else if (r_deb_cnt[i] == c_DW'(DEB_CYCLES - 1)) begin
                    r_filt[i]    <= r_sync2[i];
                    r_deb_cnt[i] <= '0;
                end else begin
                    r_deb_cnt[i] <= r_deb_cnt[i] + 1'b1;
                end
            end
        end
    end

    assign w_lvl = r_filt;
`else
    assign w_lvl = r_sync2;
`endif

    assign w_edge = w_lvl & ~r_prev;

    state_t r_state;
    logic   r_pend_in;
    logic   r_pend_out;
    logic   r_last_in;
    logic   r_ovr;
    logic   r_cnt_en;
    logic   r_up_down;
    logic   r_full;
    logic   r_empty;
    logic   r_rej_in;
    logic   r_rej_out;

    logic w_idle;
    logic w_sel_in;
    logic w_sel_out;
    logic w_at_max;
    logic w_at_zero;

    assign w_idle    = (r_state == S_IDLE);
    // Entry wins unless both are pending and entry was the last one served.
    assign w_sel_in  = r_pend_in & (~r_pend_out | ~r_last_in);
    assign w_sel_out = r_pend_out & ~w_sel_in;
    assign w_at_max  = (q >= c_MAX);
    assign w_at_zero = (q == '0);

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_prev     <= 2'b00;
            r_pend_in  <= 1'b0;
            r_pend_out <= 1'b0;
            r_ovr      <= 1'b0;
        end else begin
            r_prev <= w_lvl;
            if (w_idle && w_sel_in) begin
                r_pend_in <= 1'b0;
            end
            if (w_idle && w_sel_out) begin
                r_pend_out <= 1'b0;
            end
            // An edge that finds its request still pending is dropped.
            if (w_edge[0]) begin
                if (r_pend_in) begin
                    r_ovr <= 1'b1;
                end else begin
                    r_pend_in <= 1'b1;
                end
            end
            if (w_edge[1]) begin
                if (r_pend_out) begin
                    r_ovr <= 1'b1;
                end else begin
                    r_pend_out <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_state   <= S_IDLE;
            r_last_in <= 1'b0;
            r_cnt_en  <= 1'b0;
            r_up_down <= 1'b1;
            r_full    <= 1'b0;
            r_empty   <= 1'b1;
            r_rej_in  <= 1'b0;
            r_rej_out <= 1'b0;
        end else begin
            r_cnt_en  <= 1'b0;
            r_rej_in  <= 1'b0;
            r_rej_out <= 1'b0;
            r_full    <= w_at_max;
            r_empty   <= w_at_zero;
            case (r_state)
                S_IDLE: begin
                    if (w_sel_in) begin
                        r_last_in <= 1'b1;
                        if (w_at_max) begin
                            r_rej_in <= 1'b1;
                        end else begin
                            r_up_down <= 1'b1;
                            r_state   <= S_SET_DIR;
                        end
                    end else if (w_sel_out) begin
                        r_last_in <= 1'b0;
                        if (w_at_zero) begin
                            r_rej_out <= 1'b1;
                        end else begin
                            r_up_down <= 1'b0;
                            r_state   <= S_SET_DIR;
                        end
                    end
                end
                S_SET_DIR: begin
                    r_cnt_en <= 1'b1;
                    r_state  <= S_COUNT;
                end
                S_COUNT: begin
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign cnt_en  = r_cnt_en;
    assign up_down = r_up_down;
    assign full    = r_full;
    assign empty   = r_empty;
    assign rej_in  = r_rej_in;
    assign rej_out = r_rej_out;
    assign ovr     = r_ovr;

endmodule
`default_nettype wire

// File: tb/tb_modulo_controle_contador_ocupacao.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_modulo_controle_contador_ocupacao
// Function : Scoreboard bench for the occupancy controller with a behavioural
//            up/down counter closing the loop on q.
// Revision : 1.0 - initial release
// ============================================================================
module tb_modulo_controle_contador_ocupacao;

    localparam int WIDTH      = 7;
    localparam int MAX_COUNT  = 99;
    localparam int DEB_CYCLES = 4;
`ifdef DEBOUNCE_EN
    localparam int c_DEB = DEB_CYCLES;
    localparam int c_PW  = DEB_CYCLES + 2;
`else
    localparam int c_DEB = 0;
    localparam int c_PW  = 2;
`endif
    localparam int c_LAT_CNT = 5 + c_DEB;
    localparam int c_LAT_REJ = 4 + c_DEB;

    localparam int K_UP = 0;
    localparam int K_DN = 1;
    localparam int K_RI = 2;
    localparam int K_RO = 3;

    logic             clk = 1'b0;
    logic             clr;
    logic             sensor_in;
    logic             sensor_out;
    logic [WIDTH-1:0] q_cnt;
    logic             cnt_en;
    logic             up_down;
    logic             full;
    logic             empty;
    logic             rej_in;
    logic             rej_out;
    logic             ovr;
    logic             ld;
    logic [WIDTH-1:0] ld_val;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    typedef struct {
        int kind;
        int cyc;
    } exp_t;
    exp_t sb[$];

    modulo_controle_contador_ocupacao #(
        .WIDTH      (WIDTH),
        .MAX_COUNT  (MAX_COUNT),
        .DEB_CYCLES (DEB_CYCLES)
    ) dut (
        .clk        (clk),
        .clr        (clr),
        .sensor_in  (sensor_in),
        .sensor_out (sensor_out),
        .q          (q_cnt),
        .cnt_en     (cnt_en),
        .up_down    (up_down),
        .full       (full),
        .empty      (empty),
        .rej_in     (rej_in),
        .rej_out    (rej_out),
        .ovr        (ovr)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // External counter sharing the controller reset; ld preloads a value.
    always @(posedge clk or negedge clr) begin
        if (!clr) begin
            q_cnt <= '0;
        end else if (ld) begin
            q_cnt <= ld_val;
        end else if (cnt_en) begin
            q_cnt <= up_down ? q_cnt + 1'b1 : q_cnt - 1'b1;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic expect_ev(input int kind, input int at);
        exp_t e;
        e.kind = kind;
        e.cyc  = at;
        sb.push_back(e);
    endtask

    always @(negedge clk) begin : mon
        exp_t e;
        int   kind;
        if (clr === 1'b1 && (cnt_en === 1'b1 || rej_in === 1'b1 || rej_out === 1'b1)) begin
            if (rej_in)       kind = K_RI;
            else if (rej_out) kind = K_RO;
            else if (up_down) kind = K_UP;
            else              kind = K_DN;
            if (sb.size() == 0) begin
                check("unexpected_event", kind, 99);
            end else begin
                e = sb.pop_front();
                check("event_kind", kind, e.kind);
                check("event_cycle", cyc, e.cyc);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic load(input int v);
        @(negedge clk);
        ld     = 1'b1;
        ld_val = WIDTH'(v);
        @(negedge clk);
        ld = 1'b0;
        tick(2);
    endtask

    task automatic rise(input logic pin, input logic pout, output int c);
        @(negedge clk);
        c = cyc;
        if (pin)  sensor_in  = 1'b1;
        if (pout) sensor_out = 1'b1;
    endtask

    task automatic fall();
        tick(c_PW);
        sensor_in  = 1'b0;
        sensor_out = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        clr        = 1'b0;
        sensor_in  = 1'b0;
        sensor_out = 1'b0;
        ld         = 1'b0;
        ld_val     = '0;
        tick(3);
        check("rst_up_down", up_down, 1);
        check("rst_empty", empty, 1);
        check("rst_full", full, 0);
        check("rst_cnt_en", cnt_en, 0);
        check("rst_rej_in", rej_in, 0);
        check("rst_rej_out", rej_out, 0);
        check("rst_ovr", ovr, 0);
        clr = 1'b1;
        tick(3);

        // Single entry from q=5.
        load(5);
        check("q5_empty", empty, 0);
        rise(1'b1, 1'b0, c);
        expect_ev(K_UP, c + c_LAT_CNT);
        fall();
        tick(12 + c_DEB);
        check("entry_q", q_cnt, 6);
        check("entry_up_down", up_down, 1);

        // Single exit; leaves last_grant on the exit side.
        rise(1'b0, 1'b1, c);
        expect_ev(K_DN, c + c_LAT_CNT);
        fall();
        tick(12 + c_DEB);
        check("exit_q", q_cnt, 5);
        check("exit_up_down_holds", up_down, 0);

        // Simultaneous requests: entry first, exit four cycles later.
        load(10);
        rise(1'b1, 1'b1, c);
        expect_ev(K_UP, c + c_LAT_CNT);
        expect_ev(K_DN, c + c_LAT_CNT + 4);
        fall();
        tick(16 + c_DEB);
        check("both_q", q_cnt, 10);

        // Last accepted entry reaches capacity.
        load(98);
        check("q98_full", full, 0);
        rise(1'b1, 1'b0, c);
        expect_ev(K_UP, c + c_LAT_CNT);
        fall();
        tick(12 + c_DEB);
        check("cap_q", q_cnt, MAX_COUNT);
        check("cap_full", full, 1);

        // Entry refused at capacity.
        rise(1'b1, 1'b0, c);
        expect_ev(K_RI, c + c_LAT_REJ);
        fall();
        tick(12 + c_DEB);
        check("rej_in_q", q_cnt, MAX_COUNT);

        // Exit refused when empty.
        load(0);
        check("zero_empty", empty, 1);
        rise(1'b0, 1'b1, c);
        expect_ev(K_RO, c + c_LAT_REJ);
        fall();
        tick(12 + c_DEB);
        check("rej_out_q", q_cnt, 0);
        check("ovr_still_clear", ovr, 0);

`ifndef DEBOUNCE_EN
        // Exit keeps the FSM busy while two entry edges arrive; the second drops.
        load(20);
        @(negedge clk);
        c = cyc;
        sensor_out = 1'b1;
        expect_ev(K_DN, c + 5);
        expect_ev(K_UP, c + 9);
        @(negedge clk);
        sensor_in = 1'b1;
        @(negedge clk);
        sensor_out = 1'b0;
        @(negedge clk);
        sensor_in = 1'b0;
        @(negedge clk);
        sensor_in = 1'b1;
        tick(2);
        sensor_in = 1'b0;
        tick(14);
        check("ovr_set", ovr, 1);
        check("ovr_q", q_cnt, 20);
`else
        // Glitch shorter than the filter window produces no request.
        load(20);
        @(negedge clk);
        sensor_in = 1'b1;
        tick(2);
        sensor_in = 1'b0;
        tick(20);
        check("glitch_q", q_cnt, 20);
`endif

        // Reset asserted while cnt_en is high.
        rise(1'b1, 1'b0, c);
        expect_ev(K_UP, c + c_LAT_CNT);
        fall();
        for (int i = 0; i < 40 && cyc < c + c_LAT_CNT; i++) @(negedge clk);
        check("reach_count_cycle", cyc, c + c_LAT_CNT);
        #2;
        clr = 1'b0;
        #1;
        check("midrst_cnt_en", cnt_en, 0);
        check("midrst_ovr", ovr, 0);
        check("midrst_empty", empty, 1);
        check("midrst_up_down", up_down, 1);
        @(negedge clk);
        clr = 1'b1;
        tick(3);

        // FSM is back in IDLE and serves a fresh request.
        load(3);
        rise(1'b1, 1'b0, c);
        expect_ev(K_UP, c + c_LAT_CNT);
        fall();
        tick(12 + c_DEB);
        check("post_rst_q", q_cnt, 4);

        tick(4);
        check("scoreboard_drained", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
